sram_controller: RTL
====================

# sram_controller

Responder side of the MEM-stage memory interface. Accepts 32-bit load/store requests from the MEM stage, performs them as two 16-bit accesses on an external SRAM, and holds `ready` low while busy so the pipeline can drive `freeze = ~ready` into the pipeline registers. One access is in flight at a time, with no queuing.

## Interface
Parameters:
- `ADDR_BASE`, 1024: byte address that maps to SRAM word 0.
- `SRAM_AW`, 18: SRAM address width (16-bit half-words).
- `ACCESS_CYCLES`, 2: clock cycles each half-word access is held on the SRAM bus. Must be ≥1.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wr_en` in 1: store request. Held until `ready`.
- `rd_en` in 1: load request. Held until `ready`.
- `address` in 32: byte address, word-aligned.
- `write_data` in 32: store data.
- `read_data` out 32: load result, registered.
- `ready` out 1: 1 when idle with no request pending, or on the completion cycle.
- `sram_addr` out SRAM_AW: half-word address.
- `sram_dq_out` out 16: write data to SRAM.
- `sram_dq_in` in 16: read data from SRAM.
- `sram_dq_oe` out 1: 1 means the controller drives the DQ bus.
- `sram_we_n` out 1: active-low write strobe.
- `sram_oe_n` out 1: active-low output enable.

## Operation
- States:
  - IDLE: no access in progress.
  - LOW: lower half-word access, held for ACCESS_CYCLES cycles.
  - HIGH: upper half-word access, held for ACCESS_CYCLES cycles.
  - DONE: one cycle, signals completion.
- IDLE, `wr_en|rd_en`=1 at a clock edge:
  - latch `address`, `write_data`, and op; write wins if both requests are set;
  - load phase counter with ACCESS_CYCLES-1; go to LOW.
- LOW and HIGH: decrement the counter each cycle. On 0, LOW goes to HIGH with the counter reloaded, and HIGH goes to DONE.
- DONE goes to IDLE unconditionally.
- Address arithmetic: `w = ((address - ADDR_BASE) mod 2^32) >> 2`, truncated to SRAM_AW-1 bits.
  - LOW uses `sram_addr = {w,0}`; HIGH uses `{w,1}`.
  - Out-of-range addresses wrap silently.
- Write op:
  - `sram_dq_oe`=1 and `sram_we_n`=0 throughout LOW and HIGH;
  - `sram_dq_out` = `write_data[15:0]` in LOW, `[31:16]` in HIGH.
- Read op:
  - `sram_oe_n`=0 throughout LOW and HIGH;
  - `sram_dq_in` is sampled into `read_data[15:0]` at the final LOW edge and into `[31:16]` at the final HIGH edge.
  - `read_data` is stable from DONE until the next read's LOW phase ends.
  - Writes never modify `read_data`.
- `ready`:
  - combinational: `(state==IDLE & ~(wr_en|rd_en)) | state==DONE`;
  - 0 in the same cycle a request appears in IDLE, so freeze is immediate.
- Request deasserted or changed mid-access: ignored. The latched access completes and DONE still pulses.
- Request still asserted in the cycle after DONE: treated as a new access. The pipeline guarantees the request changes, because it advanced on the DONE edge.

## Timing
- Reset, asynchronous and immediate: state IDLE, counter 0, `read_data`=0, `sram_addr`=0, `sram_dq_out`=0, `sram_dq_oe`=0, `sram_we_n`=1, `sram_oe_n`=1. During reset, `ready` = `~(wr_en|rd_en)`.
- Reset mid-access aborts the access, leaving a partial SRAM write possible. The bus is released on the reset assertion itself.
- Latency: request seen in IDLE at cycle 0. LOW occupies cycles 1..AC, HIGH AC+1..2AC, DONE at 2AC+1, where AC = ACCESS_CYCLES. `ready` is 0 for 2AC+1 cycles.
- All SRAM outputs are registered, with no combinational path from request to SRAM pins. `sram_we_n` and `sram_oe_n` return to 1 in DONE.
- Throughput: one access per 2AC+2 cycles, counting the IDLE cycle.

## Structure
- Shared package `sram_pkg`: state enum (IDLE, LOW, HIGH, DONE) and the default ADDR_BASE constant, also used by the MEM stage for range decoding.
- One natural sub-module: `sram_phase_counter`, a loadable down-counter with a terminal-count flag, width $clog2(ACCESS_CYCLES).
- All other logic (FSM, address computation, half-word mux and capture) stays in `sram_controller`.

## Test plan
Defaults: ACCESS_CYCLES=2, so the access lasts 5 busy cycles.
- Idle, no request: `ready`=1, `sram_we_n`=1, `sram_oe_n`=1, `sram_dq_oe`=0 indefinitely. Assert `rst` mid-run: outputs return to reset values without a clock edge.
- Write 0xDEADBEEF to address 1028: `ready` 0 for exactly 5 cycles. `sram_addr`=2 with dq 0xBEEF for 2 cycles, then 3 with 0xDEAD for 2 cycles. `ready`=1 in cycle 5.
- Read from 1028 with an SRAM model holding that data: `read_data`=0xDEADBEEF in DONE, held through later idle cycles and a subsequent write to 1032.
- `wr_en` and `rd_en` both set: performs a write and `read_data` is unchanged. Separately, drop `rd_en` after 1 cycle: access still completes at cycle 5.
- Address 1020, below base: `sram_addr` = 2^18-2 then 2^18-1 (wrap). Back-to-back requests held high: new access starts the cycle after DONE.
- Assert `rst` during HIGH of a write: `sram_we_n`=1 and `sram_dq_oe`=0 immediately. After release, state is IDLE and a fresh read completes normally.

Source files
------------

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared SRAM access state encoding and default base address
package sram_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } sram_state_t;

   // MEM-stage range decoding uses the same constant, so it lives here.
   localparam logic [31:0] SRAM_ADDR_BASE = 32'd1024;

endpackage

// File: rtl/sram_phase_counter.sv
// rtl/sram_phase_counter.sv - loadable down-counter timing one half-word access phase
module sram_phase_counter #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_tc
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec) begin
         r_count <= r_count - WIDTH'(1);
      end
   end

   assign o_tc = (r_count == '0);

endmodule

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit MEM-stage load/store over a 16-bit external SRAM
module sram_controller
   import sram_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE     = SRAM_ADDR_BASE,
   parameter int          SRAM_AW       = 18,
   parameter int          ACCESS_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic               rd_en,
   input  logic [31:0]        address,
   input  logic [31:0]        write_data,
   output logic [31:0]        read_data,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [15:0]        sram_dq_out,
   input  logic [15:0]        sram_dq_in,
   output logic               sram_dq_oe,
   output logic               sram_we_n,
   output logic               sram_oe_n
);

   localparam int            CW         = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
   localparam logic [CW-1:0] PHASE_LOAD = CW'(ACCESS_CYCLES - 1);

   sram_state_t        r_state;
   sram_state_t        w_next_state;
   logic               w_req;
   logic               w_tc;
   logic               w_load;
   logic               w_dec;
   logic [31:0]        w_offset;
   logic [SRAM_AW-2:0] w_word;
   logic               w_unused_offset;
   logic [SRAM_AW-2:0] r_word;
   logic [15:0]        r_wdata_hi;
   logic               r_is_write;

   assign w_req    = wr_en | rd_en;
   // Out-of-range addresses wrap: only the word bits that fit the SRAM are kept.
   assign w_offset = address - ADDR_BASE;
   assign w_word   = w_offset[SRAM_AW:2];
   assign w_unused_offset = ^{w_offset[31:SRAM_AW+1], w_offset[1:0]};

   assign ready = ((r_state == IDLE) && !w_req) || (r_state == DONE);

   assign w_load = ((r_state == IDLE) && w_req) || ((r_state == LOW) && w_tc);
   assign w_dec  = ((r_state == LOW) || (r_state == HIGH)) && !w_tc;

   sram_phase_counter #(
      .WIDTH (CW)
   ) u_phase (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_load_val (PHASE_LOAD),
      .i_dec      (w_dec),
      .o_tc       (w_tc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_req) w_next_state = LOW;
         LOW:     if (w_tc)  w_next_state = HIGH;
         HIGH:    if (w_tc)  w_next_state = DONE;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Pins are set up on the edge that enters each phase so nothing reaches them combinationally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_word      <= '0;
         r_wdata_hi  <= '0;
         r_is_write  <= 1'b0;
         read_data   <= '0;
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_we_n   <= 1'b1;
         sram_oe_n   <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_req) begin
                  r_word      <= w_word;
                  r_wdata_hi  <= write_data[31:16];
                  r_is_write  <= wr_en;
                  sram_addr   <= {w_word, 1'b0};
                  sram_dq_out <= write_data[15:0];
                  sram_dq_oe  <= wr_en;
                  sram_we_n   <= ~wr_en;
                  sram_oe_n   <= wr_en;
               end
            end
            LOW: begin
               if (w_tc) begin
                  if (!r_is_write) read_data[15:0] <= sram_dq_in;
                  sram_addr   <= {r_word, 1'b1};
                  sram_dq_out <= r_wdata_hi;
               end
            end
            HIGH: begin
               if (w_tc) begin
                  if (!r_is_write) read_data[31:16] <= sram_dq_in;
                  sram_dq_oe <= 1'b0;
                  sram_we_n  <= 1'b1;
                  sram_oe_n  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
